button_pulser: RTL and testbench

Conditions raw Basys push-button inputs into the clean single-cycle pulses consumed by the clock-control logic (manual step pulse, auto-mode select) and other `sysclk`-domain consumers. Each button passes through a two-flop synchronizer and a per-button debounce state machine. The block emits exactly one `sysclk` pulse per debounced press. Optional hold-to-repeat turns a held manual-step button into a stream of evenly spaced step pulses.

---
 rtl/button_pulser.sv | 150 +++++++++++++++
 tb/tb_button_pulser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulser.sv
// Push-button conditioner: per-bit 2-flop synchronizer, debounce FSM and
// optional hold-to-repeat, emitting one registered sysclk pulse per accepted press.
module button_pulser #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_EN       = 0,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn,
   output logic [WIDTH-1:0] pulse,
   output logic [WIDTH-1:0] level
);

   localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   // A repeat threshold of 1 would give back-to-back pulses; floor it at 2.
   localparam int HOLD_EFF = (HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES;
   localparam int REP_EFF  = (REPEAT_CYCLES < 2) ? 2 : REPEAT_CYCLES;

   localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] DEB_V     = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_EFF - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REP_EFF - 1);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
   localparam logic [1:0] ST_HELD       = 2'd2;
   localparam logic [1:0] ST_REL_WAIT   = 2'd3;

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   // Two-flop synchronizer for the raw button levels.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync1_q <= {WIDTH{1'b0}};
         sync2_q <= {WIDTH{1'b0}};
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_btn
      logic [1:0]    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] cnt_inc_s;
      logic [CW-1:0] rep_last_s;
      logic          rep_q, rep_d;
      logic          pulse_q, pulse_d;
      logic          level_q, level_d;
      logic          s_s;

      assign s_s        = sync2_q[i];
      assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
      assign rep_last_s = rep_q ? REP_LAST : HOLD_LAST;

      // Debounce / repeat next-state logic.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rep_d   = rep_q;
         pulse_d = 1'b0;
         level_d = level_q;
         case (state_q)
            ST_IDLE: begin
               level_d = 1'b0;
               if (s_s) begin
                  state_d = ST_PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = CNT_ZERO;
               end
            end
            ST_PRESS_WAIT: begin
               if (!s_s) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == DEB_V) begin
                  state_d = ST_HELD;
                  pulse_d = 1'b1;
                  level_d = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            ST_HELD: begin
               if (!s_s) begin
                  state_d = ST_REL_WAIT;
                  cnt_d   = CNT_ONE;
               end else if ((REPEAT_EN != 0) && (cnt_q == rep_last_s)) begin
                  pulse_d = 1'b1;
                  rep_d   = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            ST_REL_WAIT: begin
               if (s_s) begin
                  state_d = ST_HELD;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == DEB_V) begin
                  state_d = ST_IDLE;
                  level_d = 1'b0;
                  rep_d   = 1'b0;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
               rep_d   = 1'b0;
               level_d = 1'b0;
            end
         endcase
      end

      // Per-button state, counter and registered outputs.
      always_ff @(posedge sysclk or posedge rst) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            rep_q   <= 1'b0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
         end
      end

      assign pulse[i] = pulse_q;
      assign level[i] = level_q;
   end

endmodule

// File: tb/tb_button_pulser.sv
// Scoreboard bench for button_pulser: two instances (repeat off / repeat on),
// expected pulse and level-change events queued at stimulus time.
module tb_button_pulser;

   logic       sysclk = 1'b0;
   logic       rst    = 1'b0;
   logic [1:0] btn_a  = 2'b00;
   logic [1:0] btn_b  = 2'b00;
   logic [1:0] pulse_a, level_a, pulse_b, level_b;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   logic [1:0] prev_la = 2'b00;
   logic [1:0] prev_lb = 2'b00;

   typedef struct {
      int         strm;
      int         cyc;
      logic [1:0] val;
   } ev_t;
   ev_t sb[$];

   button_pulser #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                   .HOLD_CYCLES(10), .REPEAT_CYCLES(3)) dut_a (
      .sysclk(sysclk), .rst(rst), .btn(btn_a), .pulse(pulse_a), .level(level_a));

   button_pulser #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                   .HOLD_CYCLES(10), .REPEAT_CYCLES(3)) dut_b (
      .sysclk(sysclk), .rst(rst), .btn(btn_b), .pulse(pulse_b), .level(level_b));

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   function automatic string strm_name(input int s);
      case (s)
         0:       return "pulse_a";
         1:       return "level_a";
         2:       return "pulse_b";
         default: return "level_b";
      endcase
   endfunction

   function automatic void expect_ev(input int s, input int c, input logic [1:0] v);
      sb.push_back('{s, c, v});
   endfunction

   function automatic void observe(input int s, input logic [1:0] v);
      int idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
         if (sb[k].strm == s) begin
            idx = k;
            break;
         end
      end
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL %s: unexpected value %b at cycle %0d, required no event", strm_name(s), v, cyc);
      end else begin
         if (sb[idx].cyc != cyc || sb[idx].val != v) begin
            errors++;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                     strm_name(s), v, cyc, sb[idx].val, sb[idx].cyc);
         end
         sb.delete(idx);
      end
   endfunction

   function automatic void check(input string name, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, got, exp);
      end
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // Monitor: every pulse and every level change must match the next queued event.
   always @(negedge sysclk) begin
      if (rst) begin
         prev_la <= level_a;
         prev_lb <= level_b;
      end else begin
         if (pulse_a != 2'b00) observe(0, pulse_a);
         if (level_a != prev_la) observe(1, level_a);
         if (pulse_b != 2'b00) observe(2, pulse_b);
         if (level_b != prev_lb) observe(3, level_b);
         prev_la <= level_a;
         prev_lb <= level_b;
      end
   end

   initial begin
      int c;
      int rep_off[6] = '{17, 20, 23, 26, 29, 32};

      #1 rst = 1'b1;
      #1;
      check("reset pulse_a", pulse_a, 2'b00);
      check("reset level_a", level_a, 2'b00);
      check("reset pulse_b", pulse_b, 2'b00);
      check("reset level_b", level_b, 2'b00);
      step(3);
      rst = 1'b0;
      step(2);

      // Clean press of bit 0, held 20 cycles.
      c = cyc; btn_a = 2'b01;
      expect_ev(0, c + 7, 2'b01);
      expect_ev(1, c + 7, 2'b01);
      step(20);
      c = cyc; btn_a = 2'b00;
      expect_ev(1, c + 7, 2'b00);
      step(12);

      // Bounce 1,0,1,1,0 then settle high.
      btn_a = 2'b01; step(1);
      btn_a = 2'b00; step(1);
      btn_a = 2'b01; step(2);
      btn_a = 2'b00; step(1);
      c = cyc; btn_a = 2'b01;
      expect_ev(0, c + 7, 2'b01);
      expect_ev(1, c + 7, 2'b01);
      step(10);

      // Two-cycle release glitch, then clean release.
      btn_a = 2'b00; step(2);
      btn_a = 2'b01; step(6);
      c = cyc; btn_a = 2'b00;
      expect_ev(1, c + 7, 2'b00);
      step(12);

      // Hold-to-repeat, 30 cycles.
      c = cyc; btn_b = 2'b01;
      expect_ev(2, c + 7, 2'b01);
      foreach (rep_off[k]) expect_ev(2, c + rep_off[k], 2'b01);
      expect_ev(3, c + 7, 2'b01);
      step(30);
      c = cyc; btn_b = 2'b00;
      expect_ev(3, c + 7, 2'b00);
      step(12);

      // Second hold: first repeat must again use the long threshold.
      c = cyc; btn_b = 2'b01;
      expect_ev(2, c + 7, 2'b01);
      expect_ev(2, c + 17, 2'b01);
      expect_ev(3, c + 7, 2'b01);
      step(15);
      c = cyc; btn_b = 2'b00;
      expect_ev(3, c + 7, 2'b00);
      step(12);

      // Both bits on the same edge.
      c = cyc; btn_a = 2'b11;
      expect_ev(0, c + 7, 2'b11);
      expect_ev(1, c + 7, 2'b11);
      step(10);
      c = cyc; btn_a = 2'b00;
      expect_ev(1, c + 7, 2'b00);
      step(12);

      // Bit 1 pressed three cycles after bit 0.
      c = cyc; btn_a = 2'b01;
      expect_ev(0, c + 7, 2'b01);
      expect_ev(1, c + 7, 2'b01);
      step(3);
      btn_a = 2'b11;
      expect_ev(0, c + 10, 2'b10);
      expect_ev(1, c + 10, 2'b11);
      step(10);
      c = cyc; btn_a = 2'b00;
      expect_ev(1, c + 7, 2'b00);
      step(12);

      // Reset during PRESS_WAIT, then during the pulse cycle.
      btn_a = 2'b01;
      step(4);
      rst = 1'b1;
      #1;
      check("rst in press_wait pulse_a", pulse_a, 2'b00);
      check("rst in press_wait level_a", level_a, 2'b00);
      step(2);
      rst = 1'b0;
      c = cyc;
      expect_ev(0, c + 7, 2'b01);
      expect_ev(1, c + 7, 2'b01);
      step(7);
      @(negedge sysclk);
      #1 rst = 1'b1;
      #1;
      check("rst in pulse cycle pulse_a", pulse_a, 2'b00);
      check("rst in pulse cycle level_a", level_a, 2'b00);
      step(2);
      rst = 1'b0;
      c = cyc;
      expect_ev(0, c + 7, 2'b01);
      expect_ev(1, c + 7, 2'b01);
      step(10);
      c = cyc; btn_a = 2'b00;
      expect_ev(1, c + 7, 2'b00);
      step(12);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         foreach (sb[k])
            $display("FAIL %s: missing event, got none, required %b at cycle %0d",
                     strm_name(sb[k].strm), sb[k].val, sb[k].cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
